reg_file_reader: RTL and testbench

- Read-out engine for the 2-port async-read / sync-write register file. It walks a contiguous, wrapping range of register addresses through one RF read port and streams each value out on a valid/ready interface.
- Used for debug dump, context save and checksum paths. It is the reader counterpart to the RF write side.
- The RF itself is external. This block only drives a read address and samples the combinational read data.

---
 rtl/reg_file_reader.sv | 148 ++++++++++++++
 tb/tb_reg_file_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_reader.sv
// reg_file_reader: walks a wrapping range of register-file addresses through
// one async read port and streams each value out on a valid/ready interface.
//
// Ports:
//   clk, rst_ni            clock, async active-low reset
//   start_i, first_addr_i  sweep request and first register
//   count_i                number of registers (clamped to 2**ADR_WIDTH)
//   abort_i                cancel an active sweep (no done_o)
//   rf_addr_o, rf_data_i   RF read address / combinational read data
//   data_o, addr_o         streamed value and its address tag
//   valid_o, ready_i       output handshake
//   last_o                 final beat of the sweep
//   busy_o, done_o         sweep active / one-cycle completion pulse
module reg_file_reader #(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADR_WIDTH  = $clog2(NUM_REGS),
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADR_WIDTH-1:0]  first_addr_i,
    input  logic [ADR_WIDTH:0]    count_i,
    input  logic                  abort_i,
    output logic [ADR_WIDTH-1:0]  rf_addr_o,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ADR_WIDTH-1:0]  addr_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [ADR_WIDTH:0] MaxCnt = (ADR_WIDTH+1)'(1 << ADR_WIDTH);

    state_e                  state_q, state_d;
    logic [ADR_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ADR_WIDTH-1:0]    rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADR_WIDTH-1:0]    addr_q, addr_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;

    logic [ADR_WIDTH:0]      cnt;
    logic [ADR_WIDTH-1:0]    ptr_inc;
    logic                    fire;

    // A request larger than the RF reads every register exactly once.
    assign cnt     = (count_i > MaxCnt) ? MaxCnt : count_i;
    assign ptr_inc = ptr_q + 1'b1;
    assign fire    = valid_q & ready_i;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        data_d    = data_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        rf_addr_o = ptr_q;

        unique case (state_q)
            IDLE: begin
                // Present the first address early so its data is ready to
                // capture on the same edge that samples start_i.
                rf_addr_o = first_addr_i;
                if (start_i) begin
                    if (cnt != '0) begin
                        data_d  = rf_data_i;
                        addr_d  = first_addr_i;
                        ptr_d   = first_addr_i;
                        rem_d   = ADR_WIDTH'(cnt - 1'b1);
                        valid_d = 1'b1;
                        last_d  = (cnt == (ADR_WIDTH+1)'(1));
                        state_d = SEND;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                // Look ahead one address on a non-final fire so the next
                // beat is captured without a bubble.
                if (fire && !last_q) begin
                    rf_addr_o = ptr_inc;
                end
                if (abort_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else if (fire) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ptr_d  = ptr_inc;
                        addr_d = ptr_inc;
                        data_d = rf_data_i;
                        rem_d  = rem_q - 1'b1;
                        last_d = (rem_q == ADR_WIDTH'(1));
                    end
                end
            end
        endcase
    end

    assign data_o  = data_q;
    assign addr_o  = addr_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q == SEND);

endmodule

// File: tb/tb_reg_file_reader.sv
// tb_reg_file_reader: randomized and directed checks of reg_file_reader
// against a queue-based model of the expected beat stream.
module tb_reg_file_reader;

    localparam int NR = 8;
    localparam int AW = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [AW-1:0] first_addr_i = '0;
    logic [AW:0]   count_i = '0;
    logic [AW-1:0] rf_addr_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] rf_data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          busy_o;
    logic          done_o;

    logic [DW-1:0] rf [NR];
    logic          we = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    always #5 clk = ~clk;

    assign rf_data_i = rf[rf_addr_o];

    always @(posedge clk) begin
        if (we) rf[wa] <= wd;
    end

    reg_file_reader #(
        .NUM_REGS  (NR),
        .ADR_WIDTH (AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .first_addr_i(first_addr_i),
        .count_i     (count_i),
        .abort_i     (abort_i),
        .rf_addr_o   (rf_addr_o),
        .rf_data_i   (rf_data_i),
        .data_o      (data_o),
        .addr_o      (addr_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Runs one sweep starting at the current negedge; returns at the
    // negedge where done_o is observed (or after the cycle budget).
    task automatic do_sweep(input logic [AW-1:0] first, input logic [AW:0] cnt,
                            input int pct, input logic [31:0] stall,
                            input bit poke, input string tag);
        beat_t         exp_q[$];
        beat_t         b;
        int            n;
        bit            got_done;
        int            fired_last;
        bit            held;
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        got_done   = 1'b0;
        fired_last = -1;
        held       = 1'b0;
        hd         = '0;
        ha         = '0;
        n = (cnt > NR) ? NR : int'(cnt);
        for (int i = 0; i < n; i++) begin
            b.a = AW'((int'(first) + i) % NR);
            b.d = rf[b.a];
            exp_q.push_back(b);
        end
        start_i      = 1'b1;
        first_addr_i = first;
        count_i      = cnt;
        ready_i      = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (valid_o !== (n > 0) || busy_o !== (n > 0) || done_o !== (n == 0)) begin
            errors++;
            $display("FAIL %s latency: valid=%b busy=%b done=%b, required beats=%0d",
                     tag, valid_o, busy_o, done_o, n);
        end
        for (int it = 0; it < 200; it++) begin
            if (held) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== hd || addr_o !== ha) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b data=%h addr=%0d, required 1 %h %0d",
                             tag, valid_o, data_o, addr_o, hd, ha);
                end
            end
            held = 1'b0;
            if (done_o === 1'b1) begin
                got_done = 1'b1;
                checks++;
                if (fired_last != it - 1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done timing: it=%0d last fire=%0d valid=%b busy=%b",
                             tag, it, fired_last, valid_o, busy_o);
                end
                break;
            end
            if (poke) begin
                start_i      = (it == 1);
                first_addr_i = (it == 1) ? AW'(5) : first;
            end
            ready_i = !stall[it % 32] && ($urandom_range(99) < pct);
            if (valid_o === 1'b1) begin
                if (ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra beat: addr=%0d data=%h, required none",
                                 tag, addr_o, data_o);
                    end else begin
                        b = exp_q.pop_front();
                        if (addr_o !== b.a || data_o !== b.d ||
                            last_o !== (exp_q.size() == 0)) begin
                            errors++;
                            $display("FAIL %s beat: addr=%0d data=%h last=%b, required %0d %h %b",
                                     tag, addr_o, data_o, last_o, b.a, b.d,
                                     exp_q.size() == 0);
                        end
                    end
                    if (last_o === 1'b1) fired_last = it;
                end else begin
                    held = 1'b1;
                    hd   = data_o;
                    ha   = addr_o;
                end
            end
            @(negedge clk);
        end
        ready_i = 1'b0;
        start_i = 1'b0;
        checks++;
        if (!got_done || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s completion: done seen=%b beats missing=%0d, required 1 and 0",
                     tag, got_done, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        first_addr_i = AW'(3);
        #1;
        checks++;
        if (valid_o !== 0 || last_o !== 0 || done_o !== 0 || busy_o !== 0 ||
            data_o !== '0 || addr_o !== '0 || rf_addr_o !== AW'(3)) begin
            errors++;
            $display("FAIL reset: v=%b l=%b d=%b b=%b data=%h addr=%0d rfa=%0d, required zeros rfa=3",
                     valid_o, last_o, done_o, busy_o, data_o, addr_o, rf_addr_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < NR; i++) rf_write(AW'(i), DW'(16'h1000 + i));
    endtask

    task automatic test_basic();
        do_sweep(AW'(2), 4'd3, 100, 32'h0, 1'b0, "basic");
        @(negedge clk);
        checks++;
        if (done_o !== 0 || busy_o !== 0 || addr_o !== AW'(4) || data_o !== 16'h1004) begin
            errors++;
            $display("FAIL idle hold: done=%b busy=%b addr=%0d data=%h, required 0 0 4 1004",
                     done_o, busy_o, addr_o, data_o);
        end
    endtask

    task automatic test_wrap();
        do_sweep(AW'(6), 4'd4, 100, 32'h0, 1'b0, "wrap");
    endtask

    task automatic test_backpressure();
        do_sweep(AW'(1), 4'd5, 100, 32'hE, 1'b0, "backpressure");
        do_sweep(AW'(4), 4'd7, 40, 32'h0, 1'b0, "random_ready");
    endtask

    task automatic test_counts();
        do_sweep(AW'(0), 4'd0, 100, 32'h0, 1'b0, "count0");
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL count0 pulse width: done=%b, required 0", done_o);
        end
        do_sweep(AW'(3), 4'd9, 100, 32'h0, 1'b0, "count9");
        do_sweep(AW'(7), 4'd8, 100, 32'h0, 1'b0, "count8");
    endtask

    task automatic test_start_ignored();
        do_sweep(AW'(0), 4'd4, 100, 32'h0, 1'b1, "start_ignored");
    endtask

    task automatic test_abort();
        start_i      = 1'b1;
        first_addr_i = AW'(1);
        count_i      = 4'd4;
        ready_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        abort_i = 1'b1;
        checks++;
        if (valid_o !== 1'b1 || addr_o !== AW'(2)) begin
            errors++;
            $display("FAIL abort beat2: valid=%b addr=%0d, required 1 2", valid_o, addr_o);
        end
        @(negedge clk);
        abort_i = 1'b0;
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 0 || busy_o !== 0 || done_o !== 0 || last_o !== 0) begin
            errors++;
            $display("FAIL abort: valid=%b busy=%b done=%b last=%b, required 0 0 0 0",
                     valid_o, busy_o, done_o, last_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done_o !== 0 || valid_o !== 0) begin
                errors++;
                $display("FAIL abort quiet: done=%b valid=%b, required 0 0", done_o, valid_o);
            end
        end
        do_sweep(AW'(5), 4'd3, 100, 32'h0, 1'b0, "after_abort");
    endtask

    task automatic test_async_reset();
        start_i      = 1'b1;
        first_addr_i = AW'(0);
        count_i      = 4'd8;
        ready_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== 0 || busy_o !== 0 || last_o !== 0 ||
            data_o !== '0 || addr_o !== '0) begin
            errors++;
            $display("FAIL async reset: valid=%b busy=%b last=%b data=%h addr=%0d, required zeros",
                     valid_o, busy_o, last_o, data_o, addr_o);
        end
        ready_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        checks++;
        if (done_o !== 0 || busy_o !== 0 || valid_o !== 0) begin
            errors++;
            $display("FAIL post reset: done=%b busy=%b valid=%b, required 0 0 0",
                     done_o, busy_o, valid_o);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] old;
        old          = rf[3];
        we           = 1'b1;
        wa           = AW'(3);
        wd           = 16'hBEEF;
        start_i      = 1'b1;
        first_addr_i = AW'(3);
        count_i      = 4'd2;
        ready_i      = 1'b0;
        @(negedge clk);
        we      = 1'b0;
        start_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || addr_o !== AW'(3) || data_o !== old) begin
            errors++;
            $display("FAIL collision: valid=%b addr=%0d data=%h, required 1 3 %h",
                     valid_o, addr_o, data_o, old);
        end
        ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (addr_o !== AW'(4) || data_o !== rf[4] || last_o !== 1'b1) begin
            errors++;
            $display("FAIL collision beat2: addr=%0d data=%h last=%b, required 4 %h 1",
                     addr_o, data_o, last_o, rf[4]);
        end
        @(negedge clk);
        ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL collision done: done=%b, required 1", done_o);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_sweep(AW'(2), 4'd2, 100, 32'h0, 1'b0, "b2b_a");
        do_sweep(AW'(6), 4'd0, 100, 32'h0, 1'b0, "b2b_b");
        do_sweep(AW'(7), 4'd3, 100, 32'h0, 1'b0, "b2b_c");
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            if (k % 4 == 0) begin
                for (int i = 0; i < NR; i++) rf_write(AW'(i), DW'($urandom));
            end
            do_sweep(AW'($urandom_range(NR - 1)), (AW+1)'($urandom_range(9)),
                     $urandom_range(30, 100), 32'h0, 1'b0, "random");
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_counts();
        test_start_ignored();
        test_abort();
        test_async_reset();
        test_collision();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
